fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Control side of the FIR MAC datapath: owns the sample delay line and coefficient bank, and drives the ALU X/B/R ports one tap per cycle.
//  Reads back the ALU accumulator y and presents one filtered result per input sample.
//  Input and output use valid/ready handshakes.
//  Sits between the sample source and the output sink, and instantiates alongside ALU.
// PARAMETERS
//  TAPS  16  number of filter taps (>=2); coef/delay index width CW=$clog2(TAPS)
//  DW    16  sample and coefficient width, two's complement
//  AW    39  accumulator width, matching the ALU y output
// PORTS
//  clk        in   1    rising-edge clock
//  R_n        in   1    asynchronous active-low reset
//  in_valid   in   1    in_sample valid
//  in_ready   out  1    sequencer can accept a sample (high only in IDLE)
//  in_sample  in   DW   new sample x[n], signed
//  coef_we    in   1    coefficient write strobe
//  coef_addr  in   CW   coefficient index k
//  coef_data  in   DW   coefficient c[k], signed
//  alu_X      out  DW   to ALU.X (sample operand)
//  alu_B      out  DW   to ALU.B (coefficient operand)
//  alu_R      out  1    to ALU.R (synchronous accumulator clear)
//  alu_y      in   AW   from ALU.y (registered accumulator)
//  out_valid  out  1    out_data holds y[n]
//  out_ready  in   1    sink accepts out_data
//  out_data   out  AW   y[n] = sum_k c[k]*d[k], signed
// BEHAVIOUR
//  Reset (R_n low, async):
//   - state=IDLE, k=0, all d[k]=0, all c[k]=0
//   - out_valid=0, out_data=0, alu_X=0, alu_B=0, alu_R=1
//  FSM states and ALU drive:
//   - IDLE: X=B=0, R=1 (ALU held clear). in_ready=1.
//     On in_valid&in_ready: shift delay line (d[0]<=in_sample, d[k]<=d[k-1]), k<=0, ->MAC.
//   - MAC: X=d[k], B=c[k], R=0. k++ each cycle. At k==TAPS-1 ->CAPTURE.
//   - CAPTURE: X=B=0, R=0 (product 0, y holds). out_data<=alu_y, out_valid<=1, ->OUT.
//   - OUT: X=B=0, R=1. When out_ready: out_valid<=0, ->IDLE.
//  Outside MAC the ALU always sees a zero product, because the ALU accumulates every clock unless R is asserted.
//  Timing:
//   - Latency: out_valid rises TAPS+1 clocks after the accept edge.
//   - Minimum period: TAPS+3 clocks per sample.
//  Handshake rules:
//   - out_data is stable while out_valid=1 && !out_ready.
//   - in_ready=0 in MAC/CAPTURE/OUT; upstream holds in_sample.
//  Coefficients:
//   - coef_we is honoured in IDLE and OUT only; writes in MAC or CAPTURE are dropped.
//   - coef_we in the same cycle as an accept: the write lands and is used by that sample.
//  Arithmetic: the ALU sign-extends each 2*DW product to AW. The sequencer does no arithmetic; it passes alu_y through unmodified.
//  Boundaries:
//   - k wraps only via the state change.
//   - in_valid and out_ready are ignored outside their states.
//   - Reset mid-MAC aborts the sample: delay line and coefs are cleared, and no output is produced.
// STRUCTURE
//  Package fir_pkg:
//   - TAPS/DW/AW defaults
//   - state encoding localparams IDLE=0, MAC=1, CAPTURE=2, OUT=3
//  Sub-module fir_delay_line: TAPS x DW shift register with shift_en, async clear, and an index-addressed read port.
//  Coefficient bank and FSM stay in this module.
// TESTING (bench instantiates fir_tap_sequencer + ALU)
//  1. Reset: R_n low, then release -> in_ready=1, out_valid=0, alu_R=1, alu_X=alu_B=0.
//  2. Impulse: c[k]=k+1, feed 1 then 15 zeros -> out_data = 1,2,...,16, each TAPS+1 clocks after accept.
//  3. Extremes: c[k]=0x8000 and sixteen samples of 0x8000 -> final out_data = 39'h04_0000_0000.
//     Then c[k]=0x8000, samples 0x7FFF -> sign-correct negative sum.
//  4. Backpressure: out_ready low 5 cycles -> out_data stable, in_ready=0; out_ready high -> IDLE next clock.
//  5. Coef write during MAC: write c[0]=0x1234 -> dropped; next sample uses the old c[0].
//  6. Reset mid-MAC at k=7 -> all state cleared; no out_valid; next impulse gives out_data=c[0].

Source files
------------

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared defaults and FSM state encoding for the FIR tap
//                sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Default filter geometry
  localparam int FIR_TAPS = 16;
  localparam int FIR_DW   = 16;
  localparam int FIR_AW   = 39;

  // Sequencer states, kept as plain 2-bit constants for legacy tools
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MAC     = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_sequencer_if
//  Description : Sample input, coefficient write, ALU drive/readback and
//                result output bundle of the FIR tap sequencer.
//                slave  = sequencer view, master = surrounding system view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int DW   = FIR_DW,
  parameter int AW   = FIR_AW
);

  localparam int CW = $clog2(TAPS);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_sample;
  logic          coef_we;
  logic [CW-1:0] coef_addr;
  logic [DW-1:0] coef_data;
  logic [DW-1:0] alu_X;
  logic [DW-1:0] alu_B;
  logic          alu_R;
  logic [AW-1:0] alu_y;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;

  modport slave (
    input  in_valid, in_sample, coef_we, coef_addr, coef_data, alu_y, out_ready,
    output in_ready, alu_X, alu_B, alu_R, out_valid, out_data
  );

  modport master (
    output in_valid, in_sample, coef_we, coef_addr, coef_data, alu_y, out_ready,
    input  in_ready, alu_X, alu_B, alu_R, out_valid, out_data
  );

endinterface
`default_nettype wire

// File: rtl/fir_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : fir_delay_line
//  Description : TAPS x DW sample shift register. New sample enters at index
//                0, older samples move toward TAPS-1. Index-addressed read.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int DW   = FIR_DW,
  parameter int CW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          R_n,
  input  logic          i_shift_en,
  input  logic [DW-1:0] i_din,
  input  logic [CW-1:0] i_rd_idx,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_d [TAPS];

  // Shift the whole line by one position when a new sample is accepted
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      for (int i = 0; i < TAPS; i++) r_d[i] <= '0;
    end else if (i_shift_en) begin
      r_d[0] <= i_din;
      for (int i = 1; i < TAPS; i++) r_d[i] <= r_d[i-1];
    end
  end

  assign o_rd_data = r_d[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fir_tap_sequencer
//  Description : Control side of the FIR MAC datapath. Owns the delay line
//                and coefficient bank, steps the external ALU through one
//                tap per clock and hands the accumulated y[n] downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS = FIR_TAPS,
  parameter int DW   = FIR_DW,
  parameter int AW   = FIR_AW
) (
  input  logic               clk,
  input  logic               R_n,
  fir_tap_sequencer_if.slave bus
);

  localparam int            CW       = $clog2(TAPS);
  localparam logic [CW-1:0] c_last_k = CW'(TAPS - 1);

  logic [1:0]    r_state;
  logic [CW-1:0] r_k;
  logic [DW-1:0] r_coef [TAPS];
  logic          r_out_valid;
  logic [AW-1:0] r_out_data;
  logic          w_accept;
  logic          w_coef_wr;
  logic [DW-1:0] w_tap;

  // Samples are only taken in IDLE; coefficient writes only land while the
  // ALU is not consuming them (IDLE and OUT).
  assign w_accept  = bus.in_valid && (r_state == IDLE);
  assign w_coef_wr = bus.coef_we && ((r_state == IDLE) || (r_state == OUT));

  fir_delay_line #(
    .TAPS (TAPS),
    .DW   (DW),
    .CW   (CW)
  ) u_delay_line (
    .clk        (clk),
    .R_n        (R_n),
    .i_shift_en (w_accept),
    .i_din      (bus.in_sample),
    .i_rd_idx   (r_k),
    .o_rd_data  (w_tap)
  );

  // Coefficient bank; a write coinciding with an accept is seen by that sample
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      for (int i = 0; i < TAPS; i++) r_coef[i] <= '0;
    end else if (w_coef_wr) begin
      r_coef[bus.coef_addr] <= bus.coef_data;
    end
  end

  // Sequencer FSM: accept, walk all taps, capture ALU result, hold for sink
  always_ff @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      r_state     <= IDLE;
      r_k         <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_k     <= '0;
            r_state <= MAC;
          end
        end
        MAC: begin
          if (r_k == c_last_k) begin
            r_k     <= '0;
            r_state <= CAPTURE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        CAPTURE: begin
          r_out_data  <= bus.alu_y;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // ALU drive: zero product outside MAC; clear held everywhere except MAC and
  // CAPTURE so the accumulator holds its final value for one capture cycle.
  always_comb begin
    bus.in_ready = (r_state == IDLE);
    bus.alu_X    = '0;
    bus.alu_B    = '0;
    bus.alu_R    = 1'b1;
    case (r_state)
      MAC: begin
        bus.alu_X = w_tap;
        bus.alu_B = r_coef[r_k];
        bus.alu_R = 1'b0;
      end
      CAPTURE: bus.alu_R = 1'b0;
      default: ;
    endcase
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_tap_sequencer
//  Description : Bench for fir_tap_sequencer with a behavioural MAC ALU and a
//                cycle-level reference model of the sequencer's observable
//                behaviour, plus directed literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_tap_sequencer;

  localparam int TAPS = 16;
  localparam int DW   = 16;
  localparam int AW   = 39;
  localparam int CW   = $clog2(TAPS);

  logic clk = 1'b0;
  logic R_n = 1'b1;
  bit   chk_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  fir_tap_sequencer_if #(.TAPS(TAPS), .DW(DW), .AW(AW)) bus ();

  fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .R_n (R_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: accumulates the sign-extended product every clock unless cleared
  logic signed [2*DW-1:0] w_prod;
  assign w_prod = $signed(bus.alu_X) * $signed(bus.alu_B);
  always @(posedge clk) begin
    if (bus.alu_R) bus.alu_y <= '0;
    else           bus.alu_y <= bus.alu_y + {{(AW-2*DW){w_prod[2*DW-1]}}, w_prod};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            cyc = 0;
  logic [DW-1:0] m_c [TAPS];
  logic [DW-1:0] m_d [TAPS];
  bit            m_idle = 1'b1;
  bit            m_busy = 1'b0;
  bit            m_valid = 1'b0;
  int            m_acc_cyc = 0;
  logic [AW-1:0] m_exp = '0;
  logic [AW-1:0] m_last = '0;

  always @(posedge clk or negedge R_n) begin
    if (!R_n) begin
      for (int k = 0; k < TAPS; k++) begin
        m_c[k] = '0;
        m_d[k] = '0;
      end
      m_idle = 1'b1; m_busy = 1'b0; m_valid = 1'b0; m_last = '0;
    end else begin : upd
      bit was_idle, was_valid;
      logic signed [63:0] sum;
      longint a, b;
      cyc++;
      was_idle  = m_idle;
      was_valid = m_valid;
      if (bus.coef_we && (was_idle || was_valid)) m_c[bus.coef_addr] = bus.coef_data;
      if (was_valid && bus.out_ready) begin
        m_valid = 1'b0;
        m_idle  = 1'b1;
      end
      if (was_idle && bus.in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) m_d[k] = m_d[k-1];
        m_d[0] = bus.in_sample;
        sum = 0;
        for (int k = 0; k < TAPS; k++) begin
          a = $signed(m_c[k]);
          b = $signed(m_d[k]);
          sum += a * b;
        end
        m_exp     = sum[AW-1:0];
        m_idle    = 1'b0;
        m_busy    = 1'b1;
        m_acc_cyc = cyc;
      end else if (m_busy && (cyc == m_acc_cyc + TAPS + 1)) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_last  = m_exp;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin : cmp
      int j;
      logic [DW-1:0] ex, eb;
      logic er;
      ex = '0; eb = '0; er = 1'b1;
      if (m_busy) begin
        j  = cyc - m_acc_cyc;
        er = 1'b0;
        if (j >= 0 && j < TAPS) begin
          ex = m_d[j];
          eb = m_c[j];
        end
      end
      check("in_ready",  64'(bus.in_ready),  64'(m_idle));
      check("out_valid", 64'(bus.out_valid), 64'(m_valid));
      check("out_data",  64'(bus.out_data),  64'(m_last));
      check("alu_R",     64'(bus.alu_R),     64'(er));
      check("alu_X",     64'(bus.alu_X),     64'(ex));
      check("alu_B",     64'(bus.alu_B),     64'(eb));
    end
  end

  // Collect every completed output handshake
  logic [AW-1:0] results [$];
  always @(negedge clk) begin
    if (R_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) results.push_back(bus.out_data);
  end

  // ---------------- drivers ----------------
  task automatic set_coef(input int addr, input logic [DW-1:0] data);
    bus.coef_we   = 1'b1;
    bus.coef_addr = CW'(addr);
    bus.coef_data = data;
    @(posedge clk); #1;
    bus.coef_we   = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] s);
    bit ok = 1'b0;
    bus.in_sample = s;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    @(posedge clk); #1;
    check("back_to_idle", 64'(ok), 64'd1);
  endtask

  function automatic logic [63:0] res_at(input int i);
    if (i >= 0 && i < results.size()) return 64'(results[i]);
    return 'x;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n0;
    bit seen;
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_data = '0; bus.out_ready = 1'b1;

    // 1. reset state
    #2 R_n = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_alu_R",     64'(bus.alu_R),     64'd1);
    check("rst_alu_X",     64'(bus.alu_X),     64'd0);
    check("rst_alu_B",     64'(bus.alu_B),     64'd0);
    check("rst_out_data",  64'(bus.out_data),  64'd0);
    @(posedge clk); #1 R_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    // 2. impulse response with c[k]=k+1
    for (int k = 0; k < TAPS; k++) set_coef(k, DW'(k + 1));
    results.delete();
    for (int n = 0; n < TAPS; n++) begin
      send((n == 0) ? 16'd1 : 16'd0);
      wait_idle();
    end
    check("impulse_count", 64'(results.size()), 64'(TAPS));
    for (int i = 0; i < TAPS; i++) check("impulse_y", res_at(i), 64'(i + 1));

    // 3. extremes
    for (int k = 0; k < TAPS; k++) set_coef(k, 16'h8000);
    results.delete();
    for (int n = 0; n < TAPS; n++) begin
      send(16'h8000);
      wait_idle();
    end
    check("ext_min_min", res_at(TAPS - 1), 64'(39'h04_0000_0000));
    results.delete();
    for (int n = 0; n < TAPS; n++) begin
      send(16'h7FFF);
      wait_idle();
    end
    check("ext_min_max", res_at(TAPS - 1), 64'(39'h7C_0008_0000));

    // 4. output backpressure
    bus.out_ready = 1'b0;
    send(16'h0000);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("bp_valid_seen", 64'(seen), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(bus.in_ready),  64'd0);
      check("bp_valid_held",   64'(bus.out_valid), 64'd1);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_idle",  64'(bus.in_ready),  64'd1);
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;

    // 5. coefficient write during MAC is dropped
    for (int k = 1; k < TAPS; k++) set_coef(k, 16'h0000);
    set_coef(0, 16'd2);
    results.delete();
    send(16'd5);
    set_coef(0, 16'h1234);
    wait_idle();
    send(16'd3);
    wait_idle();
    check("mac_wr_y0", res_at(0), 64'd10);
    check("mac_wr_y1", res_at(1), 64'd6);

    // 6. reset in the middle of MAC
    send(16'd9);
    repeat (7) @(posedge clk);
    #1 R_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 R_n = 1'b1;
    n0 = results.size();
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_output", 64'(results.size()), 64'(n0));
    set_coef(0, 16'h0055);
    send(16'd1);
    wait_idle();
    check("abort_count", 64'(results.size()), 64'(n0 + 1));
    check("abort_impulse", res_at(n0), 64'h55);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
